// File: rtl/ddram_wr_coalescer_if.sv
// Bundle of the tile_writer single-word write port and the DDR3 Avalon write burst channel.
// The coalescer sits on the slave modport; the producer/memory environment on the master.
interface ddram_wr_coalescer_if;
    logic [28:0] in_addr;
    logic [63:0] in_data;
    logic [7:0]  in_be;
    logic        in_req;
    logic        in_ack;
    logic        in_busy;
    logic        flush;
    logic        idle;
    logic        DDRAM_BUSY;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    modport master (
        output in_addr, in_data, in_be, in_req, flush, DDRAM_BUSY,
        input  in_ack, in_busy, idle, DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport slave (
        input  in_addr, in_data, in_be, in_req, flush, DDRAM_BUSY,
        output in_ack, in_busy, idle, DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
endinterface

// File: rtl/ddram_wr_coalescer.sv
// Collects consecutive qword writes into Avalon bursts of up to MAX_BURST beats.
// state   | meaning
// S_FILL  | accepting writes into the buffer, watching for a flush trigger
// S_BURST | streaming the buffered entries out as one Avalon burst
module ddram_wr_coalescer #(
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 8
) (
    input logic           clk,
    input logic           reset_n,
    ddram_wr_coalescer_if.slave bus
);
    localparam int IW = $clog2(MAX_BURST);
    localparam int CW = IW + 1;

    typedef enum logic {S_FILL, S_BURST} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] beat_q;
    logic [28:0]   base_q;
    logic [7:0]    timer_q;
    logic          flush_pend_q;
    logic          in_ack_q;
    logic          we_q;
    logic [28:0]   addr_q;
    logic [7:0]    bcnt_q;
    logic [63:0]   din_q;
    logic [7:0]    be_q;

    logic [63:0]   data_mem [MAX_BURST];
    logic [7:0]    be_mem   [MAX_BURST];

    logic [28:0]   next_addr;
    logic          full;
    logic          offer;
    logic          addr_ok;
    logic          go_burst;
    logic          accept;

    assign next_addr = base_q + 29'(cnt_q);
    assign full      = (cnt_q == CW'(MAX_BURST));
    // in_ack_q gating stops a held request from being taken twice
    assign offer     = (state_q == S_FILL) && bus.in_req && !in_ack_q;
    assign addr_ok   = (cnt_q == '0) ||
                       ((bus.in_addr == next_addr) && (next_addr[IW-1:0] != '0));
    assign go_burst  = (state_q == S_FILL) && (cnt_q != '0) &&
                       (full || (offer && !addr_ok) || (timer_q == 8'(TIMEOUT)) || flush_pend_q);
    assign accept    = offer && !full && addr_ok && !go_burst;

    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[cnt_q[IW-1:0]] <= bus.in_data;
            be_mem[cnt_q[IW-1:0]]   <= bus.in_be;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FILL;
            cnt_q        <= '0;
            beat_q       <= '0;
            base_q       <= '0;
            timer_q      <= '0;
            flush_pend_q <= 1'b0;
            in_ack_q     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            bcnt_q       <= '0;
            din_q        <= '0;
            be_q         <= '0;
        end else begin
            in_ack_q <= accept;
            case (state_q)
                S_FILL: begin
                    if (go_burst) begin
                        state_q      <= S_BURST;
                        we_q         <= 1'b1;
                        addr_q       <= base_q;
                        bcnt_q       <= 8'(cnt_q);
                        din_q        <= data_mem[0];
                        be_q         <= be_mem[0];
                        beat_q       <= CW'(1);
                        timer_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end else begin
                        if (accept) begin
                            if (cnt_q == '0) base_q <= bus.in_addr;
                            cnt_q   <= cnt_q + 1'b1;
                            timer_q <= '0;
                        end else if ((cnt_q != '0) && (timer_q != 8'(TIMEOUT))) begin
                            timer_q <= timer_q + 8'd1;
                        end
                        // a flush with nothing buffered (and nothing arriving) is dropped
                        if (bus.flush && ((cnt_q != '0) || accept)) flush_pend_q <= 1'b1;
                        else if ((cnt_q == '0) && !accept)           flush_pend_q <= 1'b0;
                    end
                end
                S_BURST: begin
                    if (bus.flush) flush_pend_q <= 1'b1;
                    if (!bus.DDRAM_BUSY) begin
                        if (beat_q == cnt_q) begin
                            we_q    <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= S_FILL;
                        end else begin
                            din_q  <= data_mem[beat_q[IW-1:0]];
                            be_q   <= be_mem[beat_q[IW-1:0]];
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign bus.in_ack         = in_ack_q;
    assign bus.in_busy        = (state_q == S_BURST) || full;
    assign bus.idle           = (state_q == S_FILL) && (cnt_q == '0) && !in_ack_q;
    assign bus.DDRAM_WE       = we_q;
    assign bus.DDRAM_ADDR     = addr_q;
    assign bus.DDRAM_BURSTCNT = bcnt_q;
    assign bus.DDRAM_DIN      = din_q;
    assign bus.DDRAM_BE       = be_q;
endmodule

// File: tb/tb_ddram_wr_coalescer.sv
// Directed bench: expected beats/bursts are queued at drive time and popped by a negedge monitor.
module tb_ddram_wr_coalescer;
    localparam int MB = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ddram_wr_coalescer_if dif();

    ddram_wr_coalescer #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int beat_idx = 0;
    int bursts_done = 0;
    int acks = 0;
    int nwr = 0;
    logic [71:0] exp_beats [$];
    logic [36:0] exp_bursts [$];
    logic [28:0] cur_addr = '0;
    logic [7:0]  cur_cnt = '0;
    logic [71:0] mon_b;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            beat_idx = 0;
        end else begin
            if (dif.in_ack) acks++;
            if (dif.DDRAM_WE) begin
                if (beat_idx == 0) begin
                    chk("burst_expected", 72'(exp_bursts.size() != 0), 72'(1));
                    if (exp_bursts.size() != 0) {cur_addr, cur_cnt} = exp_bursts.pop_front();
                end
                chk("burst_addr", 72'(dif.DDRAM_ADDR), 72'(cur_addr));
                chk("burst_cnt", 72'(dif.DDRAM_BURSTCNT), 72'(cur_cnt));
                chk("in_busy_in_burst", 72'(dif.in_busy), 72'(1));
                if (!dif.DDRAM_BUSY) begin
                    chk("beat_expected", 72'(exp_beats.size() != 0), 72'(1));
                    if (exp_beats.size() != 0) begin
                        mon_b = exp_beats.pop_front();
                        chk("beat_din", 72'(dif.DDRAM_DIN), 72'(mon_b[71:8]));
                        chk("beat_be", 72'(dif.DDRAM_BE), 72'(mon_b[7:0]));
                    end
                    beat_idx++;
                    if (beat_idx == int'(cur_cnt)) begin
                        beat_idx = 0;
                        bursts_done++;
                    end
                end else if (exp_beats.size() != 0) begin
                    mon_b = exp_beats[0];
                    chk("stall_din", 72'(dif.DDRAM_DIN), 72'(mon_b[71:8]));
                    chk("stall_be", 72'(dif.DDRAM_BE), 72'(mon_b[7:0]));
                end
            end else if (beat_idx != 0) begin
                chk("no_bubble", 72'(dif.DDRAM_WE), 72'(1));
            end
        end
    end

    task automatic wr(input logic [28:0] a);
        logic [63:0] d;
        logic [7:0]  be;
        int n;
        d  = {$urandom, $urandom};
        be = 8'($urandom);
        dif.in_addr = a;
        dif.in_data = d;
        dif.in_be   = be;
        dif.in_req  = 1'b1;
        exp_beats.push_back({d, be});
        nwr++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dif.in_ack && n < 300);
        chk("ack_seen", 72'(n < 300), 72'(1));
        @(posedge clk); #1;
        dif.in_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(dif.idle && !dif.DDRAM_WE) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 72'(n < 300), 72'(1));
        chk({tag, "_drained"}, 72'(exp_beats.size()), 72'(0));
    endtask

    task automatic wait_we(output int n);
        n = 0;
        while (!dif.DDRAM_WE && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_beat(input int idx, input string tag);
        int n;
        n = 0;
        while (!(dif.DDRAM_WE && beat_idx == idx) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 72'(n < 100), 72'(1));
    endtask

    initial begin
        int n;
        dif.in_addr    = '0;
        dif.in_data    = '0;
        dif.in_be      = '0;
        dif.in_req     = 1'b0;
        dif.flush      = 1'b0;
        dif.DDRAM_BUSY = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", 72'(dif.idle), 72'(1));
        chk("rst_in_busy", 72'(dif.in_busy), 72'(0));
        chk("rst_in_ack", 72'(dif.in_ack), 72'(0));
        chk("rst_we", 72'(dif.DDRAM_WE), 72'(0));
        chk("rst_bcnt", 72'(dif.DDRAM_BURSTCNT), 72'(0));
        chk("rst_addr", 72'(dif.DDRAM_ADDR), 72'(0));
        chk("rst_din", 72'(dif.DDRAM_DIN), 72'(0));
        chk("rst_be", 72'(dif.DDRAM_BE), 72'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // full 16-beat row
        exp_bursts.push_back({29'h100, 8'd16});
        for (int i = 0; i < 16; i++) wr(29'h100 + 29'(i));
        wait_idle("t1_done");
        chk("t1_bursts", 72'(bursts_done), 72'(1));

        // address discontinuity
        exp_bursts.push_back({29'h100, 8'd2});
        exp_bursts.push_back({29'h200, 8'd1});
        wr(29'h100);
        wr(29'h101);
        wr(29'h200);
        chk("t2_ack_after_burst", 72'(bursts_done), 72'(2));
        wait_idle("t2_done");
        chk("t2_bursts", 72'(bursts_done), 72'(3));

        // idle timeout
        exp_bursts.push_back({29'h040, 8'd1});
        wr(29'h040);
        wait_we(n);
        chk("t3_timeout_latency", 72'(n), 72'(TO));
        wait_idle("t3_done");
        chk("t3_idle", 72'(dif.idle), 72'(1));

        // alignment break then explicit flush
        exp_bursts.push_back({29'h10E, 8'd2});
        exp_bursts.push_back({29'h110, 8'd1});
        wr(29'h10E);
        wr(29'h10F);
        wr(29'h110);
        dif.flush = 1'b1;
        @(posedge clk); #1;
        dif.flush = 1'b0;
        wait_we(n);
        chk("t4_flush_latency", 72'(n), 72'(1));
        wait_idle("t4_done");
        chk("t4_bursts", 72'(bursts_done), 72'(6));

        // waitrequest stall on beat 3
        exp_bursts.push_back({29'h300, 8'd16});
        for (int i = 0; i < 16; i++) wr(29'h300 + 29'(i));
        wait_beat(3, "t5_reach_beat3");
        dif.DDRAM_BUSY = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("t5_in_busy", 72'(dif.in_busy), 72'(1));
            chk("t5_we_held", 72'(dif.DDRAM_WE), 72'(1));
        end
        dif.DDRAM_BUSY = 1'b0;
        wait_idle("t5_done");
        chk("t5_bursts", 72'(bursts_done), 72'(7));

        // reset mid-burst
        exp_bursts.push_back({29'h400, 8'd16});
        for (int i = 0; i < 16; i++) wr(29'h400 + 29'(i));
        wait_beat(7, "t6_reach_beat7");
        reset_n = 1'b0;
        #1;
        chk("t6_we_async", 72'(dif.DDRAM_WE), 72'(0));
        exp_beats.delete();
        exp_bursts.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_idle", 72'(dif.idle), 72'(1));
        chk("t6_in_ack", 72'(dif.in_ack), 72'(0));
        chk("t6_we", 72'(dif.DDRAM_WE), 72'(0));
        exp_bursts.push_back({29'h000, 8'd1});
        wr(29'h000);
        wait_idle("t6_fresh");
        chk("t6_bursts", 72'(bursts_done), 72'(8));

        chk("ack_total", 72'(acks), 72'(nwr));
        chk("burst_q_empty", 72'(exp_bursts.size()), 72'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
